// File: rtl/prbs_pkg.sv
// Shared PRBS7 definitions (x^7+x^6+1) for generator and checker.
package prbs_pkg;

  localparam int PRBS_W = 7;
  localparam int TAP_A  = 6;
  localparam int TAP_B  = 5;

  localparam logic [1:0] ST_HUNT   = 2'b00;
  localparam logic [1:0] ST_VERIFY = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  function automatic logic prbs7_bit(
    input logic [PRBS_W-1:0] s
  );
    return s[TAP_A] ^ s[TAP_B];
  endfunction

  function automatic logic [PRBS_W-1:0] prbs7_next(
    input logic [PRBS_W-1:0] s
  );
    return {s[PRBS_W-2:0], prbs7_bit(s)};
  endfunction

endpackage

// File: rtl/prbs_chk_window.sv
// Loss-of-lock monitor: counts valid bits and errors per window.
module prbs_chk_window #(
  parameter int WIN_LEN  = 64,
  parameter int LOSS_THR = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic step,
  input  logic err,
  output logic loss
);

  localparam int CW = $clog2(WIN_LEN);
  localparam int EW = $clog2(LOSS_THR + 1);

  logic [CW-1:0] win;
  logic [EW-1:0] werr;
  logic [EW-1:0] werr_next;

  assign werr_next = werr + EW'(err);
  // The error on the final bit of a window is judged before the window clears.
  assign loss = step && (werr_next == EW'(LOSS_THR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win  <= '0;
      werr <= '0;
    end else if (restart) begin
      win  <= '0;
      werr <= '0;
    end else if (step) begin
      if (win == CW'(WIN_LEN - 1)) begin
        win  <= '0;
        werr <= '0;
      end else begin
        win  <= win + CW'(1);
        werr <= werr_next;
      end
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS7 receive checker: hunt, verify, lock, count errors, detect loss.
// Optional PRBS_CHK_BITCNT_EN adds bit_count of valid bits seen while locked.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int WIN_LEN  = 64,
  parameter int LOSS_THR = 8,
  parameter int ERR_W    = 16
) (
  input  logic             clock_25,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
`ifdef PRBS_CHK_BITCNT_EN
  output logic [31:0]      bit_count,
`endif
  output logic [1:0]       state
);

  logic [PRBS_W-1:0] r;
  logic [PRBS_W-1:0] r_rx;
  logic [2:0]        fill;
  logic [7:0]        match;
  logic              mis;
  logic              loss;
  logic              win_step;
  logic              win_restart;

  assign r_rx        = {r[PRBS_W-2:0], bit_in};
  assign mis         = bit_in ^ prbs7_bit(r);
  assign locked      = (state == ST_LOCKED);
  assign win_step    = bit_valid && !clear && locked;
  assign win_restart = clear || !locked;

  prbs_chk_window #(
    .WIN_LEN  (WIN_LEN),
    .LOSS_THR (LOSS_THR)
  ) u_window (
    .clk     (clock_25),
    .rst_n   (reset),
    .restart (win_restart),
    .step    (win_step),
    .err     (mis),
    .loss    (loss)
  );

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state     <= ST_HUNT;
      r         <= '0;
      fill      <= '0;
      match     <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clear) begin
        state     <= ST_HUNT;
        fill      <= '0;
        match     <= '0;
        err_count <= '0;
      end else if (bit_valid) begin
        case (state)
          ST_HUNT: begin
            r <= r_rx;
            if (fill == 3'd6) begin
              fill <= '0;
              // All-zero is the LFSR lockup state; keep hunting.
              if (r_rx != '0) begin
                state <= ST_VERIFY;
                match <= '0;
              end
            end else begin
              fill <= fill + 3'd1;
            end
          end
          ST_VERIFY: begin
            r <= r_rx;
            if (r_rx == '0) begin
              state <= ST_HUNT;
              fill  <= '0;
            end else if (!mis) begin
              match <= match + 8'd1;
              if (match == 8'(LOCK_CNT - 1))
                state <= ST_LOCKED;
            end else begin
              match <= '0;
            end
          end
          ST_LOCKED: begin
            // Free-run so a single line error is not fed back.
            r <= prbs7_next(r);
            if (mis) begin
              err_pulse <= 1'b1;
              if (!(&err_count))
                err_count <= err_count + ERR_W'(1);
            end
            if (loss) begin
              state <= ST_HUNT;
              fill  <= '0;
            end
          end
          default: begin
            state <= ST_HUNT;
            fill  <= '0;
          end
        endcase
      end
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset)
      bit_count <= '0;
    else if (clear)
      bit_count <= '0;
    else if (win_step && !(&bit_count))
      bit_count <= bit_count + 32'd1;
  end
`endif

endmodule
